// File: rtl/mips_isa_pkg.sv
// MIPS instruction-set constants shared by the loader and its field encoder:
// op_sel codes, opcode/funct values and the loader FSM state encoding.
package mips_isa_pkg;

  // Host-side op_sel codes
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SLT  = 4'd4;
  localparam logic [3:0] OP_LW   = 4'd5;
  localparam logic [3:0] OP_SW   = 4'd6;
  localparam logic [3:0] OP_BEQ  = 4'd7;
  localparam logic [3:0] OP_BNE  = 4'd8;
  localparam logic [3:0] OP_J    = 4'd9;
  localparam logic [3:0] OP_ADDI = 4'd10;
  localparam logic [3:0] OP_ANDI = 4'd11;
  localparam logic [3:0] OP_ORI  = 4'd12;
  localparam logic [3:0] OP_SLTI = 4'd13;

  // Primary opcodes
  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_BNE   = 6'b000101;
  localparam logic [5:0] OPC_J     = 6'b000010;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_ANDI  = 6'b001100;
  localparam logic [5:0] OPC_ORI   = 6'b001101;
  localparam logic [5:0] OPC_SLTI  = 6'b001010;

  // R-type funct codes
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2
  } state_e;

  // R-type word: shamt is always zero for the supported operations
  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] funct);
    return {OPC_RTYPE, rs, rt, rd, 5'd0, funct};
  endfunction

  // I-type word
  function automatic logic [31:0] enc_i(input logic [5:0] opc, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Host/IMEM bundle of the instruction loader. The master side is the boot
// host (drives beats and session control); the slave side is the loader.
interface instr_encoder_loader_if #(parameter int ADDR_W = 6);
  logic              start;
  logic              finish;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        op_sel;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [15:0]       imm;
  logic [25:0]       target;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   word_count;
  logic              full;
  logic              done;
  logic              err_illegal;

  modport master (
    output start, finish, in_valid, op_sel, rs, rt, rd, imm, target,
    input  in_ready, imem_we, imem_addr, imem_wdata, word_count, full, done, err_illegal
  );

  modport slave (
    input  start, finish, in_valid, op_sel, rs, rt, rd, imm, target,
    output in_ready, imem_we, imem_addr, imem_wdata, word_count, full, done, err_illegal
  );
endinterface

// File: rtl/instr_field_encoder.sv
// Combinational encoder: op_sel plus register/immediate fields -> 32-bit MIPS
// word. legal is low for op_sel codes with no instruction behind them.
module instr_field_encoder
  import mips_isa_pkg::*;
(
  input  logic [3:0]  op_sel,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic        legal,
  output logic [31:0] word
);

  // Select instruction format and opcode/funct from op_sel
  always_comb begin
    legal = 1'b1;
    word  = 32'd0;
    case (op_sel)
      OP_ADD:  word = enc_r(rs, rt, rd, FN_ADD);
      OP_SUB:  word = enc_r(rs, rt, rd, FN_SUB);
      OP_AND:  word = enc_r(rs, rt, rd, FN_AND);
      OP_OR:   word = enc_r(rs, rt, rd, FN_OR);
      OP_SLT:  word = enc_r(rs, rt, rd, FN_SLT);
      OP_LW:   word = enc_i(OPC_LW,   rs, rt, imm);
      OP_SW:   word = enc_i(OPC_SW,   rs, rt, imm);
      OP_BEQ:  word = enc_i(OPC_BEQ,  rs, rt, imm);
      OP_BNE:  word = enc_i(OPC_BNE,  rs, rt, imm);
      OP_J:    word = {OPC_J, target};
      OP_ADDI: word = enc_i(OPC_ADDI, rs, rt, imm);
      OP_ANDI: word = enc_i(OPC_ANDI, rs, rt, imm);
      OP_ORI:  word = enc_i(OPC_ORI,  rs, rt, imm);
      OP_SLTI: word = enc_i(OPC_SLTI, rs, rt, imm);
      default: begin
        legal = 1'b0;
        word  = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Instruction loader: accepts symbolic instruction beats during a load
// session, encodes them and writes them to consecutive IMEM words from 0.
// The write appears one cycle after the beat is accepted; the counter stops
// at DEPTH words without wrapping.
module instr_encoder_loader
  import mips_isa_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input logic                   clk,
  input logic                   reset_n,
  instr_encoder_loader_if.slave bus
);

  localparam int              CW       = ADDR_W + 1;
  localparam logic [ADDR_W:0] LAST_CNT = CW'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              full_q, full_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              in_ready_q, in_ready_d;

  logic              legal_s;
  logic [31:0]       word_s;
  logic              accept_s, wr_s, ill_s, last_s, start_s;

  instr_field_encoder u_enc (
    .op_sel (bus.op_sel),
    .rs     (bus.rs),
    .rt     (bus.rt),
    .rd     (bus.rd),
    .imm    (bus.imm),
    .target (bus.target),
    .legal  (legal_s),
    .word   (word_s)
  );

  assign accept_s = bus.in_valid && (state_q == ST_LOAD);
  assign wr_s     = accept_s && legal_s;
  assign ill_s    = accept_s && !legal_s;
  assign last_s   = wr_s && (cnt_q == LAST_CNT);
  assign start_s  = bus.start && (state_q == ST_IDLE);

  // Session FSM: finish takes priority over reaching the last word
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) state_d = ST_LOAD;
        else           state_d = ST_IDLE;
      end
      ST_LOAD: begin
        if (bus.finish) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (last_s) begin
          state_d = ST_FULL;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_FULL: begin
        if (bus.finish) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d = (state_d == ST_LOAD);
  end

  // Write pointer, status flags and IMEM write-port next values
  always_comb begin
    cnt_d   = cnt_q;
    full_d  = full_q;
    err_d   = err_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (start_s) begin
      cnt_d  = '0;
      full_d = 1'b0;
      err_d  = 1'b0;
    end else if (wr_s) begin
      we_d    = 1'b1;
      addr_d  = cnt_q[ADDR_W-1:0];
      wdata_d = word_s;
      cnt_d   = cnt_q + CW'(1);
      if (last_s) full_d = 1'b1;
      else        full_d = full_q;
    end else if (ill_s) begin
      err_d = 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State and output registers; reset abandons any pending write
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      we_q       <= 1'b0;
      full_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      full_q     <= full_d;
      done_q     <= done_d;
      err_q      <= err_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.imem_we     = we_q;
  assign bus.imem_addr   = addr_q;
  assign bus.imem_wdata  = wdata_q;
  assign bus.word_count  = cnt_q;
  assign bus.full        = full_q;
  assign bus.done        = done_q;
  assign bus.err_illegal = err_q;

endmodule
